sp_ram_arb: RTL

SP_RAM_ARB -- requirements
Module: sp_ram_arb

---
 rtl/sp_ram_arb.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sp_ram_arb.sv
// sp_ram_arb: two-port round-robin arbiter in front of a single-port RAM.
// Each port can lock the RAM across consecutive accesses. The RAM is
// assumed to return read data one cycle after its enable.
// Every accepted access, read or write, gets a one-cycle rvalid pulse.
// Optional feature: define SP_RAM_ARB_RESP_REG_EN to add one register
// stage on the response path. Latency becomes 2 and throughput is unchanged.
module sp_ram_arb #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // port 0
    input  logic                    p0_req_i,
    input  logic                    p0_lock_i,
    output logic                    p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    // port 1
    input  logic                    p1_req_i,
    input  logic                    p1_lock_i,
    output logic                    p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    // RAM port
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    // Lock ownership: which port, if any, was granted last cycle with lock set.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } own_e;

    own_e                  own_state_r;
    own_e                  own_next_s;
    logic                  last_gnt_r;   // 0: port 0 granted last, 1: port 1
    logic                  last_next_s;
    logic                  hold0_s;
    logic                  hold1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic [1:0]            rsp_vld_r;    // one-hot owner of the access in RAM
    logic                  rsp_rd_r;     // that access was a read
    logic                  rsp_rd_next_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;

    // Owner holds the RAM only while it keeps both req and lock asserted.
    always_comb begin
        hold0_s = 1'b0;
        hold1_s = 1'b0;
        if (own_state_r == OWN_P0) begin
            hold0_s = p0_req_i & p0_lock_i;
        end else if (own_state_r == OWN_P1) begin
            hold1_s = p1_req_i & p1_lock_i;
        end else begin
            hold0_s = 1'b0;
            hold1_s = 1'b0;
        end
    end

    // Grant selection: lock owner first, otherwise round-robin on a tie.
    // Grants are blocked while reset is asserted.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (hold0_s) begin
            gnt0_s = 1'b1;
        end else if (hold1_s) begin
            gnt1_s = 1'b1;
        end else if (p0_req_i && p1_req_i) begin
            if (last_gnt_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (p0_req_i) begin
            gnt0_s = 1'b1;
        end else if (p1_req_i) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next ownership and round-robin pointer, both follow every grant.
    always_comb begin
        own_next_s  = OWN_NONE;
        last_next_s = last_gnt_r;
        if (gnt0_s) begin
            last_next_s = 1'b0;
            own_next_s  = p0_lock_i ? OWN_P0 : OWN_NONE;
        end else if (gnt1_s) begin
            last_next_s = 1'b1;
            own_next_s  = p1_lock_i ? OWN_P1 : OWN_NONE;
        end else begin
            last_next_s = last_gnt_r;
            own_next_s  = OWN_NONE;
        end
    end

    // Arbitration state; reset points at port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_state_r <= OWN_NONE;
            last_gnt_r  <= 1'b1;
        end else begin
            own_state_r <= own_next_s;
            last_gnt_r  <= last_next_s;
        end
    end

    assign p0_gnt_o = gnt0_s;
    assign p1_gnt_o = gnt1_s;

    // Forward the granted port's request to the RAM and drive zeros when idle.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                ram_en_o    = 1'b1;
                ram_we_o    = p0_we_i;
                ram_addr_o  = p0_addr_i;
                ram_be_o    = p0_be_i;
                ram_wdata_o = p0_wdata_i;
            end
            2'b10: begin
                ram_en_o    = 1'b1;
                ram_we_o    = p1_we_i;
                ram_addr_o  = p1_addr_i;
                ram_be_o    = p1_be_i;
                ram_wdata_o = p1_wdata_i;
            end
            default: begin
                ram_en_o    = 1'b0;
                ram_we_o    = 1'b0;
                ram_addr_o  = '0;
                ram_be_o    = '0;
                ram_wdata_o = '0;
            end
        endcase
    end

    // Remember whether the access being granted now is a read.
    always_comb begin
        rsp_rd_next_s = 1'b0;
        if (gnt0_s) begin
            rsp_rd_next_s = ~p0_we_i;
        end else if (gnt1_s) begin
            rsp_rd_next_s = ~p1_we_i;
        end else begin
            rsp_rd_next_s = 1'b0;
        end
    end

    // First response stage: which port gets this cycle's RAM result.
    // Reset drops any access still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_r <= 2'b00;
            rsp_rd_r  <= 1'b0;
        end else begin
            rsp_vld_r <= {gnt1_s, gnt0_s};
            rsp_rd_r  <= rsp_rd_next_s;
        end
    end

    // RAM read data is passed on only for reads; write responses carry zero.
    always_comb begin
        rsp_data_s = '0;
        if (rsp_rd_r && (rsp_vld_r != 2'b00)) begin
            rsp_data_s = ram_rdata_i;
        end else begin
            rsp_data_s = '0;
        end
    end

`ifdef SP_RAM_ARB_RESP_REG_EN
    logic [1:0]            rsp2_vld_r;
    logic [DATA_WIDTH-1:0] rsp2_data_r;

    // Extra response stage: delays both valid and data by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp2_vld_r  <= 2'b00;
            rsp2_data_r <= '0;
        end else begin
            rsp2_vld_r  <= rsp_vld_r;
            rsp2_data_r <= rsp_data_s;
        end
    end

    // Route the registered response to its port.
    always_comb begin
        p0_rvalid_o = rsp2_vld_r[0];
        p1_rvalid_o = rsp2_vld_r[1];
        p0_rdata_o  = '0;
        p1_rdata_o  = '0;
        if (rsp2_vld_r[0]) begin
            p0_rdata_o = rsp2_data_r;
        end else if (rsp2_vld_r[1]) begin
            p1_rdata_o = rsp2_data_r;
        end else begin
            p0_rdata_o = '0;
            p1_rdata_o = '0;
        end
    end
`else
    // Route the single-cycle response to its port.
    always_comb begin
        p0_rvalid_o = rsp_vld_r[0];
        p1_rvalid_o = rsp_vld_r[1];
        p0_rdata_o  = '0;
        p1_rdata_o  = '0;
        if (rsp_vld_r[0]) begin
            p0_rdata_o = rsp_data_s;
        end else if (rsp_vld_r[1]) begin
            p1_rdata_o = rsp_data_s;
        end else begin
            p0_rdata_o = '0;
            p1_rdata_o = '0;
        end
    end
`endif

endmodule
